// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus the
// valid/ready handshake that hands fetched instructions to decode.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and holds
// the result for decode; a branch redirect squashes held and in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_taken,
  input  logic [31:0]      b_pc,
  fetch_unit_if.master     bus,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      if_pc_q        <= '0;
      if_instr_q     <= '0;
      misaligned     <= 1'b0;
      redirect_count <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misaligned <= b_taken && (b_pc[1:0] != 2'b00);
      if (b_taken && (redirect_count != '1))
        redirect_count <= redirect_count + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    bus.imem_req_valid = (state_q == S_REQ) && !b_taken;
    bus.imem_req_addr  = pc_q;
    bus.if_valid       = (state_q == S_HOLD) && !b_taken;
    bus.if_pc          = if_pc_q;
    bus.if_instr       = if_instr_q;

    if (b_taken) begin
      // A pending response must still be drained, so WAIT without data
      // parks in DROP rather than going straight back to REQ.
      pc_d = {b_pc[31:2], 2'b00};
      unique case (state_q)
        S_REQ:   state_d = S_REQ;
        S_WAIT:  state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: if (bus.imem_req_ready) state_d = S_WAIT;
        S_WAIT:
          if (bus.imem_resp_valid) begin
            if_instr_d = bus.imem_resp_data;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        S_HOLD: if (bus.if_ready) state_d = S_REQ;
        S_DROP: if (bus.imem_resp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural imem with programmable latency,
// a scoreboard of expected (pc, instr) pairs and a decode-side monitor.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_taken;
  logic [31:0] b_pc;
  logic        misaligned;
  logic [3:0]  redirect_count;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .b_taken        (b_taken),
    .b_pc           (b_pc),
    .bus            (bus),
    .misaligned     (misaligned),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_in_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_pc_q.push_back(a);
    exp_in_q.push_back(mem_word(a));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the cycle presenting a request for address a.
  task automatic wait_req(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_addr == a) found = 1'b1;
    end
    check("wait_req_found", {31'b0, found}, 32'd1);
  endtask

  // Instruction memory model: accept sampled at negedge, response driven after the edge.
  int unsigned mem_lat = 1;
  bit          pend    = 1'b0;
  int unsigned cnt     = 0;
  logic [31:0] paddr   = '0;

  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = bus.imem_req_addr;
      end
      @(posedge clk);
      #2;
      bus.imem_resp_valid = 1'b0;
      if (pend && rst_n) begin
        cnt--;
        if (cnt == 0) begin
          pend                = 1'b0;
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = mem_word(paddr);
        end
      end
    end
  end

  // Decode-side monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.if_valid && bus.if_ready) begin
        if (exp_pc_q.size() == 0) begin
          check("unexpected_handshake_pc", bus.if_pc, 32'hxxxx_xxxx);
        end else begin
          check("hs_pc", bus.if_pc, exp_pc_q.pop_front());
          check("hs_instr", bus.if_instr, exp_in_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    b_taken            = 1'b0;
    b_pc               = '0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    expect_fetch(32'h100);
    expect_fetch(32'h104);
    expect_fetch(32'h108);
    expect_fetch(32'h10C);

    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    check("rst_count", {28'b0, redirect_count}, 32'd0);
    check("rst_req_addr", bus.imem_req_addr, 32'h100);

    next_cycle();
    rst_n = 1'b1;
    @(negedge clk); check("c1_if_valid", {31'b0, bus.if_valid}, 32'd0);
    @(negedge clk); check("c2_if_valid", {31'b0, bus.if_valid}, 32'd0);
    @(negedge clk); check("c3_if_valid", {31'b0, bus.if_valid}, 32'd1);

    // Stall decode while 0x10C is held
    wait_req(32'h10C);
    next_cycle();
    bus.if_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_if_valid", {31'b0, bus.if_valid}, 32'd1);
      check("stall_if_pc", bus.if_pc, 32'h10C);
      check("stall_if_instr", bus.if_instr, mem_word(32'h10C));
      check("stall_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    end
    next_cycle();
    bus.if_ready = 1'b1;
    mem_lat      = 3;

    // Redirect while waiting on a slow response
    next_cycle();
    @(negedge clk);
    check("req_110_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("req_110_addr", bus.imem_req_addr, 32'h110);
    next_cycle();
    b_taken = 1'b1;
    b_pc    = 32'h200;
    expect_fetch(32'h200);
    @(negedge clk);
    check("wait_redir_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("wait_redir_req", {31'b0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    b_taken = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    check("drop1_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("drop1_req", {31'b0, bus.imem_req_valid}, 32'd0);
    check("count_1", {28'b0, redirect_count}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("drop2_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check("drop2_req", {31'b0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("after_drop_req", {31'b0, bus.imem_req_valid}, 32'd1);
    check("after_drop_addr", bus.imem_req_addr, 32'h200);

    // Redirect in HOLD with decode ready: no handshake
    wait_req(32'h204);
    next_cycle();
    next_cycle();
    b_taken = 1'b1;
    b_pc    = 32'h300;
    expect_fetch(32'h300);
    @(negedge clk);
    check("hold_redir_if_valid", {31'b0, bus.if_valid}, 32'd0);
    next_cycle();
    b_taken = 1'b0;
    @(negedge clk);
    check("hold_redir_addr", bus.imem_req_addr, 32'h300);
    check("count_2", {28'b0, redirect_count}, 32'd2);

    // Misaligned target, response arriving in the redirect cycle
    wait_req(32'h304);
    next_cycle();
    b_taken = 1'b1;
    b_pc    = 32'h203;
    expect_fetch(32'h200);
    @(negedge clk);
    check("mis_before", {31'b0, misaligned}, 32'd0);
    next_cycle();
    b_taken = 1'b0;
    @(negedge clk);
    check("mis_pulse", {31'b0, misaligned}, 32'd1);
    check("mis_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("mis_req_addr", bus.imem_req_addr, 32'h200);
    next_cycle();
    @(negedge clk);
    check("mis_after", {31'b0, misaligned}, 32'd0);
    check("count_3", {28'b0, redirect_count}, 32'd3);

    // PC wraparound
    wait_req(32'h204);
    next_cycle();
    b_taken = 1'b1;
    b_pc    = 32'hFFFF_FFFC;
    expect_fetch(32'hFFFF_FFFC);
    next_cycle();
    b_taken = 1'b0;
    @(negedge clk);
    check("top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    check("count_4", {28'b0, redirect_count}, 32'd4);
    wait_req(32'h0);
    check("wrap_addr", bus.imem_req_addr, 32'h0);

    // Counter saturation
    next_cycle();
    b_taken = 1'b1;
    b_pc    = 32'h500;
    repeat (11) next_cycle();
    next_cycle();
    b_taken = 1'b0;
    @(negedge clk);
    check("count_sat", {28'b0, redirect_count}, 32'd15);
    check("sat_misaligned", {31'b0, misaligned}, 32'd0);
    next_cycle();
    b_taken = 1'b1;
    b_pc    = 32'h400;
    expect_fetch(32'h400);
    next_cycle();
    b_taken = 1'b0;
    @(negedge clk);
    check("count_held", {28'b0, redirect_count}, 32'd15);
    check("sat_redir_addr", bus.imem_req_addr, 32'h400);

    for (int i = 0; i < 100 && exp_pc_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_pc_q.size(), 32'd0);
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
